// File: rtl/hd_pkg.sv
// rtl/hd_pkg.sv - shared state encoding and width helpers for the Hamming-distance accumulator
package hd_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        SCAN   = 3'd2,
        UPDATE = 3'd3,
        FINISH = 3'd4
    } state_t;

    // Distance width: must hold the value WIDTH itself
    function automatic int dw_of(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int nib_of(input int width);
        return width / 4;
    endfunction

    function automatic int idx_w_of(input int width);
        return (width > 4) ? $clog2(width / 4) : 1;
    endfunction

endpackage

// File: rtl/hamming_dist_accum_if.sv
// rtl/hamming_dist_accum_if.sv - word-pair input stream with valid/ready handshake
interface hamming_dist_accum_if #(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/hamming_dist_accum_lut4.sv
// rtl/hamming_dist_accum_lut4.sv - 4-bit popcount lookup table
module hamming_dist_accum_lut4 (
    input  logic [3:0] nib,
    output logic [2:0] cnt
);

    always_comb begin
        cnt = 3'd0;
        case (nib)
            4'h0: cnt = 3'd0;
            4'h1: cnt = 3'd1;
            4'h2: cnt = 3'd1;
            4'h3: cnt = 3'd2;
            4'h4: cnt = 3'd1;
            4'h5: cnt = 3'd2;
            4'h6: cnt = 3'd2;
            4'h7: cnt = 3'd3;
            4'h8: cnt = 3'd1;
            4'h9: cnt = 3'd2;
            4'hA: cnt = 3'd2;
            4'hB: cnt = 3'd3;
            4'hC: cnt = 3'd2;
            4'hD: cnt = 3'd3;
            4'hE: cnt = 3'd3;
            4'hF: cnt = 3'd4;
        endcase
    end

endmodule

// File: rtl/hamming_dist_accum.sv
// rtl/hamming_dist_accum.sv - nibble-serial Hamming distance with per-batch min/max/count
module hamming_dist_accum
    import hd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8,
    localparam int DW   = dw_of(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    hamming_dist_accum_if.slave   s_in,
    output logic                  dist_valid,
    output logic [DW-1:0]         dist_out,
    output logic [DW-1:0]         min_dist,
    output logic [DW-1:0]         max_dist,
    output logic [CNT_W-1:0]      pair_cnt,
    output logic                  busy,
    output logic                  done
);

    localparam int NIB = nib_of(WIDTH);
    localparam int IW  = idx_w_of(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t          state, state_nxt;
    logic [WIDTH-1:0] x;
    logic            last_q;
    logic [DW-1:0]   sum;
    logic [DW-1:0]   sum_nxt;
    logic [IW-1:0]   idx;
    logic [2:0]      nib_cnt;
    logic            scan_end;

    hamming_dist_accum_lut4 u_lut (
        .nib (x[3:0]),
        .cnt (nib_cnt)
    );

    assign sum_nxt  = sum + DW'(nib_cnt);
    assign scan_end = (state == SCAN) && (idx == IW'(NIB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        s_in.in_ready = 1'b0;
        busy          = (state != IDLE);
        dist_valid    = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ACCEPT;
            end
            ACCEPT: begin
                s_in.in_ready = 1'b1;
                if (s_in.in_valid) state_nxt = SCAN;
            end
            SCAN: begin
                if (scan_end) state_nxt = UPDATE;
            end
            UPDATE: begin
                dist_valid = 1'b1;
                state_nxt  = last_q ? FINISH : ACCEPT;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // dist_out is loaded on the final SCAN edge so it is already stable while dist_valid is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x        <= '0;
            last_q   <= 1'b0;
            sum      <= '0;
            idx      <= '0;
            dist_out <= '0;
            min_dist <= DW'(WIDTH);
            max_dist <= '0;
            pair_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        min_dist <= DW'(WIDTH);
                        max_dist <= '0;
                        pair_cnt <= '0;
                    end
                end
                ACCEPT: begin
                    if (s_in.in_valid) begin
                        x      <= s_in.in_a ^ s_in.in_b;
                        last_q <= s_in.in_last;
                        sum    <= '0;
                        idx    <= '0;
                    end
                end
                SCAN: begin
                    sum <= sum_nxt;
                    x   <= x >> 4;
                    idx <= idx + IW'(1);
                    if (scan_end) dist_out <= sum_nxt;
                end
                UPDATE: begin
                    if (dist_out < min_dist) min_dist <= dist_out;
                    if (dist_out > max_dist) max_dist <= dist_out;
                    if (pair_cnt != CNT_MAX) pair_cnt <= pair_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_dist_accum.sv
// tb/tb_hamming_dist_accum.sv - directed table-driven bench for hamming_dist_accum
module tb_hamming_dist_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_last;
    logic [15:0] in_a;
    logic [15:0] in_b;

    logic        dv0, busy0, done0;
    logic [4:0]  dout0, min0, max0;
    logic [7:0]  cnt0;
    logic        dv1, busy1, done1;
    logic [4:0]  dout1, min1, max1;
    logic [1:0]  cnt1;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt, exp_min, exp_max;

    hamming_dist_accum_if #(.WIDTH(16)) bus0 ();
    hamming_dist_accum_if #(.WIDTH(16)) bus1 ();

    assign bus0.in_valid = in_valid;
    assign bus0.in_a     = in_a;
    assign bus0.in_b     = in_b;
    assign bus0.in_last  = in_last;
    assign bus1.in_valid = in_valid;
    assign bus1.in_a     = in_a;
    assign bus1.in_b     = in_b;
    assign bus1.in_last  = in_last;

    hamming_dist_accum #(.WIDTH(16), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .s_in(bus0),
        .dist_valid(dv0), .dist_out(dout0), .min_dist(min0), .max_dist(max0),
        .pair_cnt(cnt0), .busy(busy0), .done(done0)
    );

    hamming_dist_accum #(.WIDTH(16), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .s_in(bus1),
        .dist_valid(dv1), .dist_out(dout1), .min_dist(min1), .max_dist(max1),
        .pair_cnt(cnt1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          last;
        int          d;
        bit          hold;
        bit          first;
        bit          mid_start;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset();
        check("rst_in_ready", int'(bus0.in_ready), 0);
        check("rst_dist_valid", int'(dv0), 0);
        check("rst_dist_out", int'(dout0), 0);
        check("rst_min", int'(min0), 16);
        check("rst_max", int'(max0), 0);
        check("rst_cnt", int'(cnt0), 0);
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_cnt_u1", int'(cnt1), 0);
        check("rst_min_u1", int'(min1), 16);
    endtask

    task automatic begin_batch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", int'(busy0), 1);
        check("start_in_ready", int'(bus0.in_ready), 1);
        check("start_min", int'(min0), 16);
        check("start_max", int'(max0), 0);
        check("start_cnt", int'(cnt0), 0);
        exp_cnt = 0;
        exp_min = 16;
        exp_max = 0;
    endtask

    // Caller is at a negedge in ACCEPT; returns at the negedge after UPDATE
    task automatic send(input logic [15:0] a, input logic [15:0] b, input bit last,
                        input int d, input bit hold);
        int n;
        int lat;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        n = 0;
        while (!bus0.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_ready", int'(bus0.in_ready), 1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = hold;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_last  = 1'($urandom);
        while (!dv0 && lat < 20) begin
            if (hold) check("scan_ready_low", int'(bus0.in_ready), 0);
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (hold) begin
                in_a = 16'($urandom);
                in_b = 16'($urandom);
            end
        end
        check("latency", lat, 5);
        check("dist_out", int'(dout0), d);
        check("dist_out_u1", int'(dout1), d);
        check("dist_valid_u1", int'(dv1), 1);
        exp_cnt++;
        if (d < exp_min) exp_min = d;
        if (d > exp_max) exp_max = d;
        @(negedge clk);
        check("dist_valid_pulse", int'(dv0), 0);
        check("min_dist", int'(min0), exp_min);
        check("max_dist", int'(max0), exp_max);
        check("pair_cnt", int'(cnt0), exp_cnt);
        check("pair_cnt_sat", int'(cnt1), (exp_cnt > 3) ? 3 : exp_cnt);
        check("min_dist_u1", int'(min1), exp_min);
        check("done", int'(done0), int'(last));
        check("done_u1", int'(done1), int'(last));
        if (!hold) in_valid = 1'b0;
    endtask

    initial begin
        int saw;
        // batch: single pair
        vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 16, 1'b0, 1'b1, 1'b0});
        // batch: mixed distances
        vecs.push_back('{16'h00F0, 16'h0000, 1'b0,  4, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{16'h1234, 16'h1234, 1'b0,  0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16'hAAAA, 16'h5555, 1'b1, 16, 1'b0, 1'b0, 1'b0});
        // batch: in_valid held high with changing data during SCAN
        vecs.push_back('{16'h0F0F, 16'h0000, 1'b0,  8, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{16'h8001, 16'h0001, 1'b0,  1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{16'h0003, 16'h0000, 1'b1,  2, 1'b0, 1'b0, 1'b0});
        // batch: five pairs, saturation on the narrow counter, start mid-batch
        vecs.push_back('{16'hFFFF, 16'hFFFE, 1'b0,  1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{16'h1111, 16'h0000, 1'b0,  4, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16'hC000, 16'h0000, 1'b0,  2, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{16'hF00F, 16'h0FF0, 1'b0, 16, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{16'h0000, 16'h0001, 1'b1,  1, 1'b0, 1'b0, 1'b0});

        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = '0;
        in_b     = '0;
        exp_cnt  = 0;
        exp_min  = 16;
        exp_max  = 0;
        repeat (3) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;

        // in_valid in IDLE must be ignored
        in_valid = 1'b1;
        in_a     = 16'hFFFF;
        in_last  = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", int'(busy0), 0);
        check("idle_cnt", int'(cnt0), 0);
        check("idle_dist_valid", int'(dv0), 0);
        check("idle_in_ready", int'(bus0.in_ready), 0);
        in_valid = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].first) begin_batch();
            if (vecs[i].mid_start) start = 1'b1;
            send(vecs[i].a, vecs[i].b, vecs[i].last, vecs[i].d, vecs[i].hold);
            if (vecs[i].last) begin
                @(negedge clk);
                check("finish_busy", int'(busy0), 0);
                check("finish_done", int'(done0), 0);
                check("hold_dist_out", int'(dout0), vecs[i].d);
            end
        end

        // reset during the second SCAN cycle
        begin_batch();
        in_valid = 1'b1;
        in_a     = 16'hFFFF;
        in_b     = 16'h0000;
        in_last  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("scan2_busy", int'(busy0), 1);
        rst_n = 1'b0;
        #1;
        chk_reset();
        saw = 0;
        repeat (6) begin
            @(negedge clk);
            if (dv0 || done0 || dv1 || done1) saw = 1;
        end
        check("no_pulse_in_reset", saw, 0);
        rst_n = 1'b1;

        begin_batch();
        send(16'h5A5A, 16'h0000, 1'b1, 8, 1'b0);
        @(negedge clk);
        check("post_reset_busy", int'(busy0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
